dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin core/host arbiter for one data-memory port.
// Define DMEM_ARB_STATS_EN to add the saturating conflict_cnt output.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out,
  output logic          busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [7:0]    conflict_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC_C = 2'd1;
  localparam logic [1:0] ACC_H = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_d;
  logic          last_host;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          in_acc;
  logic          eff_c;
  logic          eff_h;
  logic          pend;
  logic          pick_h;

  assign core_gnt = (state == ACC_C);
  assign host_gnt = (state == ACC_H);
  assign in_acc   = core_gnt | host_gnt;
  assign busy     = (state != IDLE);

  // The port being granted this cycle may still hold req; ignore it.
  assign eff_c  = core_req & ~core_gnt;
  assign eff_h  = host_req & ~host_gnt;
  assign pend   = eff_c | eff_h;
  assign pick_h = eff_h & ~(eff_c & last_host);

  assign mem_wr_en  = in_acc & lat_we;
  assign mem_addr   = lat_addr;
  assign mem_dat_in = lat_wdata;

  always_comb begin
    state_d = IDLE;
    priority case (1'b1)
      pend:             state_d = pick_h ? ACC_H : ACC_C;
      in_acc & ~lat_we: state_d = RESP;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_host <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_d;
      if (pend) begin
        last_host <= pick_h;
        lat_we    <= pick_h ? host_we    : core_we;
        lat_addr  <= pick_h ? host_addr  : core_addr;
        lat_wdata <= pick_h ? host_wdata : core_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      core_rdata  <= '0;
      host_rdata  <= '0;
    end else begin
      core_rvalid <= core_gnt & ~lat_we;
      host_rvalid <= host_gnt & ~lat_we;
      if (core_gnt & ~lat_we)
        core_rdata <= mem_dat_out;
      if (host_gnt & ~lat_we)
        host_rdata <= mem_dat_out;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      conflict_cnt <= 8'd0;
    else if (eff_c & eff_h & (conflict_cnt != 8'hFF))
      conflict_cnt <= conflict_cnt + 8'd1;
  end
`endif

endmodule
